// File: rtl/unidade_controle.sv
// Multicycle control unit: sequences fetch, decode, execute, memory and
// write-back steps, driving datapath strobes and ALU selects from the FSM state.
module unidade_controle #(
    parameter int MEM_LAT = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    output logic       reset_wire,
    output logic       WRITE_PC,
    output logic       WRITE_INSTRUCTION,
    output logic       load_ab,
    output logic       load_aluout,
    output logic       reg_write,
    output logic       mem_data_wr,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       pc_src,
    output logic [2:0] operacao,
    output logic [3:0] state_out,
    output logic       halted
);

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_EXEC_I = 4'd4,
        S_ADDR   = 4'd5,
        S_MEM_RD = 4'd6,
        S_MEM_WB = 4'd7,
        S_MEM_WR = 4'd8,
        S_ALU_WB = 4'd9,
        S_BRANCH = 4'd10,
        S_HALT   = 4'd11
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;
    localparam logic [2:0] ALU_XOR  = 3'b101;

    // Counter reload value: a wait state of MEM_LAT cycles ends when it hits zero.
    localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT - 1);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       storeOp_q, storeOp_d;

    logic       rValid, iValid;
    logic [2:0] rOp, iOp;

    always_comb begin
        rValid = 1'b1;
        rOp    = ALU_PASS;
        case (funct3)
            3'b000:  rOp = funct7_5 ? ALU_SUB : ALU_ADD;
            3'b111:  rOp = ALU_AND;
            3'b110:  rOp = ALU_OR;
            3'b100:  rOp = ALU_XOR;
            default: rValid = 1'b0;
        endcase
    end

    always_comb begin
        iValid = 1'b1;
        iOp    = ALU_PASS;
        case (funct3)
            3'b000:  iOp = ALU_ADD;
            3'b111:  iOp = ALU_AND;
            3'b110:  iOp = ALU_OR;
            3'b100:  iOp = ALU_XOR;
            default: iValid = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        storeOp_d = storeOp_q;
        case (state_q)
            S_RESET: begin
                state_d = S_FETCH;
                cnt_d   = LAT_LOAD;
            end
            S_FETCH: begin
                if (cnt_q == 3'd0) state_d = S_DECODE;
                else               cnt_d   = cnt_q - 3'd1;
            end
            S_DECODE: begin
                case (opcode)
                    OP_R:      state_d = S_EXEC_R;
                    OP_I:      state_d = S_EXEC_I;
                    OP_LOAD: begin
                        state_d   = S_ADDR;
                        storeOp_d = 1'b0;
                    end
                    OP_STORE: begin
                        state_d   = S_ADDR;
                        storeOp_d = 1'b1;
                    end
                    OP_BRANCH: state_d = S_BRANCH;
                    default:   state_d = S_HALT;
                endcase
            end
            S_EXEC_R: state_d = rValid ? S_ALU_WB : S_HALT;
            S_EXEC_I: state_d = iValid ? S_ALU_WB : S_HALT;
            S_ADDR: begin
                state_d = storeOp_q ? S_MEM_WR : S_MEM_RD;
                cnt_d   = LAT_LOAD;
            end
            S_MEM_RD: begin
                if (cnt_q == 3'd0) state_d = S_MEM_WB;
                else               cnt_d   = cnt_q - 3'd1;
            end
            S_MEM_WB, S_MEM_WR, S_ALU_WB: begin
                state_d = S_FETCH;
                cnt_d   = LAT_LOAD;
            end
            S_BRANCH: begin
                if (funct3 == 3'b000 || funct3 == 3'b001) begin
                    state_d = S_FETCH;
                    cnt_d   = LAT_LOAD;
                end else begin
                    state_d = S_HALT;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_RESET;
            cnt_q     <= 3'd0;
            storeOp_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            storeOp_q <= storeOp_d;
        end
    end

    // Outputs decode only from the state registers, except the branch compare
    // which must follow the ALU zero flag produced during BRANCH itself.
    always_comb begin
        reset_wire        = 1'b0;
        WRITE_PC          = 1'b0;
        WRITE_INSTRUCTION = 1'b0;
        load_ab           = 1'b0;
        load_aluout       = 1'b0;
        reg_write         = 1'b0;
        mem_data_wr       = 1'b0;
        mem_to_reg        = 1'b0;
        alu_src_a         = 1'b0;
        alu_src_b         = 2'b00;
        pc_src            = 1'b0;
        operacao          = ALU_PASS;
        halted            = 1'b0;
        case (state_q)
            S_RESET: reset_wire = 1'b1;
            S_FETCH: begin
                if (cnt_q == 3'd0) begin
                    WRITE_INSTRUCTION = 1'b1;
                    WRITE_PC          = 1'b1;
                    alu_src_b         = 2'b01;
                    operacao          = ALU_ADD;
                end
            end
            S_DECODE: begin
                load_ab     = 1'b1;
                load_aluout = 1'b1;
                alu_src_b   = 2'b10;
                operacao    = ALU_ADD;
            end
            S_EXEC_R: begin
                alu_src_a   = 1'b1;
                load_aluout = 1'b1;
                operacao    = rOp;
            end
            S_EXEC_I: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                load_aluout = 1'b1;
                operacao    = iOp;
            end
            S_ADDR: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                load_aluout = 1'b1;
                operacao    = ALU_ADD;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: mem_data_wr = 1'b1;
            S_ALU_WB: reg_write   = 1'b1;
            S_BRANCH: begin
                alu_src_a = 1'b1;
                operacao  = ALU_SUB;
                pc_src    = 1'b1;
                if (funct3 == 3'b000)      WRITE_PC = zero;
                else if (funct3 == 3'b001) WRITE_PC = ~zero;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    assign state_out = state_q;

endmodule

// File: tb/tb_unidade_controle.sv
// Directed bench for unidade_controle: one instance with MEM_LAT=1 and one
// with MEM_LAT=3 share the inputs; useL3 selects which one is observed.
module tb_unidade_controle;

    logic       CLK;
    logic       RST;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       useL3;

    logic       rw1, wpc1, wi1, lab1, lalu1, regw1, memwr1, m2r1, srca1, pcsrc1, halt1;
    logic [1:0] srcb1;
    logic [2:0] op1;
    logic [3:0] st1;
    logic       rw3, wpc3, wi3, lab3, lalu3, regw3, memwr3, m2r3, srca3, pcsrc3, halt3;
    logic [1:0] srcb3;
    logic [2:0] op3;
    logic [3:0] st3;

    typedef struct packed {
        logic [3:0] st;
        logic       halted;
        logic       rw;
        logic       wpc;
        logic       wi;
        logic       lab;
        logic       lalu;
        logic       regw;
        logic       memwr;
        logic       m2r;
        logic       srca;
        logic [1:0] srcb;
        logic       pcsrc;
        logic [2:0] op;
    } obs_t;

    obs_t o1, o3, obs;

    assign o1  = {st1, halt1, rw1, wpc1, wi1, lab1, lalu1, regw1, memwr1, m2r1, srca1, srcb1, pcsrc1, op1};
    assign o3  = {st3, halt3, rw3, wpc3, wi3, lab3, lalu3, regw3, memwr3, m2r3, srca3, srcb3, pcsrc3, op3};
    assign obs = useL3 ? o3 : o1;

    unidade_controle #(.MEM_LAT(1)) dut1 (
        .CLK(CLK), .RST(RST), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5), .zero(zero),
        .reset_wire(rw1), .WRITE_PC(wpc1), .WRITE_INSTRUCTION(wi1), .load_ab(lab1),
        .load_aluout(lalu1), .reg_write(regw1), .mem_data_wr(memwr1), .mem_to_reg(m2r1),
        .alu_src_a(srca1), .alu_src_b(srcb1), .pc_src(pcsrc1), .operacao(op1),
        .state_out(st1), .halted(halt1)
    );

    unidade_controle #(.MEM_LAT(3)) dut3 (
        .CLK(CLK), .RST(RST), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5), .zero(zero),
        .reset_wire(rw3), .WRITE_PC(wpc3), .WRITE_INSTRUCTION(wi3), .load_ab(lab3),
        .load_aluout(lalu3), .reg_write(regw3), .mem_data_wr(memwr3), .mem_to_reg(m2r3),
        .alu_src_a(srca3), .alu_src_b(srcb3), .pc_src(pcsrc3), .operacao(op3),
        .state_out(st3), .halted(halt3)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int numCompared   = 0;
    int numMismatched = 0;
    int regwCnt, m2rCnt, memwrCnt, wiCnt;
    int execOp, execSrcB;
    int expSeq[$];

    task automatic checkOutput(input string tag, input int actual, input int expected);
        numCompared++;
        if (actual != expected) begin
            numMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z);
        opcode   = op;
        funct3   = f3;
        funct7_5 = f7;
        zero     = z;
    endtask

    // Advance one clock and tally the strobes seen in the newly entered state.
    task automatic step();
        @(posedge CLK);
        #1;
        if (obs.regw)  regwCnt++;
        if (obs.m2r)   m2rCnt++;
        if (obs.memwr) memwrCnt++;
        if (obs.wi)    wiCnt++;
        if (obs.st == 4'd3 || obs.st == 4'd4) begin
            execOp   = obs.op;
            execSrcB = obs.srcb;
        end
    endtask

    task automatic resetBoth(input string tag);
        #2;
        RST = 1'b1;
        #2;
        checkOutput({tag, ".rstState"}, obs.st, 0);
        checkOutput({tag, ".rstWire"}, obs.rw, 1);
        checkOutput({tag, ".rstStrobes"}, {obs.wpc, obs.wi, obs.lab, obs.lalu, obs.regw, obs.memwr, obs.m2r, obs.halted}, 0);
        @(posedge CLK);
        #1;
        RST      = 1'b0;
        regwCnt  = 0;
        m2rCnt   = 0;
        memwrCnt = 0;
        wiCnt    = 0;
        execOp   = -1;
        execSrcB = -1;
    endtask

    task automatic runSeq(input string tag);
        for (int i = 0; i < expSeq.size(); i++) begin
            checkOutput($sformatf("%s.st%0d", tag, i), obs.st, expSeq[i]);
            if (i != expSeq.size() - 1) step();
        end
    endtask

    initial begin
        int badHalt;
        RST   = 1'b1;
        useL3 = 1'b0;
        applyStimulus(7'b0110011, 3'b000, 1'b1, 1'b0);

        // R-type SUB at MEM_LAT=1, stepped state by state
        resetBoth("rsub");
        checkOutput("rsub.reset", obs.st, 0);
        checkOutput("rsub.resetWire", obs.rw, 1);
        step();
        checkOutput("rsub.fetch", obs.st, 1);
        checkOutput("rsub.fetchStrobes", {obs.wi, obs.wpc, obs.srca, obs.srcb, obs.pcsrc, obs.op}, 'b11_0_01_0_001);
        step();
        checkOutput("rsub.decode", obs.st, 2);
        checkOutput("rsub.decodeOut", {obs.lab, obs.lalu, obs.srca, obs.srcb, obs.op}, 'b1_1_0_10_001);
        step();
        checkOutput("rsub.execR", obs.st, 3);
        checkOutput("rsub.execOut", {obs.srca, obs.srcb, obs.lalu, obs.op}, 'b1_00_1_010);
        step();
        checkOutput("rsub.aluWb", {obs.st, obs.regw, obs.m2r}, 'b1001_1_0);
        step();
        checkOutput("rsub.backToFetch", obs.st, 1);
        checkOutput("rsub.regwCnt", regwCnt, 1);

        // I-type AND at MEM_LAT=1
        applyStimulus(7'b0010011, 3'b111, 1'b1, 1'b0);
        resetBoth("iand");
        expSeq = '{0, 1, 2, 4, 9, 1};
        runSeq("iand");
        checkOutput("iand.op", execOp, 3);
        checkOutput("iand.srcB", execSrcB, 2);

        // R-type XOR with funct7_5=1 is still XOR
        applyStimulus(7'b0110011, 3'b100, 1'b1, 1'b0);
        resetBoth("rxor");
        expSeq = '{0, 1, 2, 3, 9, 1};
        runSeq("rxor");
        checkOutput("rxor.op", execOp, 5);

        // Undefined R-type funct3 goes to HALT
        applyStimulus(7'b0110011, 3'b001, 1'b0, 1'b0);
        resetBoth("rbad");
        expSeq = '{0, 1, 2, 3, 11};
        runSeq("rbad");
        checkOutput("rbad.regwCnt", regwCnt, 0);

        // Load at MEM_LAT=3: 9 cycles from first FETCH to next FETCH
        useL3 = 1'b1;
        applyStimulus(7'b0000011, 3'b010, 1'b0, 1'b0);
        resetBoth("load3");
        expSeq = '{0, 1, 1, 1, 2, 5, 6, 6, 6, 7, 1};
        runSeq("load3");
        checkOutput("load3.regwCnt", regwCnt, 1);
        checkOutput("load3.m2rCnt", m2rCnt, 1);
        checkOutput("load3.wiCnt", wiCnt, 1);

        // Store at MEM_LAT=1
        useL3 = 1'b0;
        applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0);
        resetBoth("store");
        expSeq = '{0, 1, 2, 5, 8, 1};
        runSeq("store");
        checkOutput("store.memwrCnt", memwrCnt, 1);
        checkOutput("store.regwCnt", regwCnt, 0);

        // BEQ / BNE in BRANCH, zero toggled within the cycle
        applyStimulus(7'b1100011, 3'b000, 1'b0, 1'b1);
        resetBoth("br");
        step();
        step();
        step();
        checkOutput("br.state", obs.st, 10);
        checkOutput("br.beqTaken", {obs.wpc, obs.pcsrc, obs.srca, obs.srcb, obs.op}, 'b1_1_1_00_010);
        zero = 1'b0;
        #1;
        checkOutput("br.beqNotTaken", obs.wpc, 0);
        funct3 = 3'b001;
        #1;
        checkOutput("br.bneTaken", obs.wpc, 1);
        zero = 1'b1;
        #1;
        checkOutput("br.bneNotTaken", obs.wpc, 0);
        step();
        checkOutput("br.nextFetch", obs.st, 1);

        // Illegal opcode halts and stays halted with no strobes
        applyStimulus(7'b1111111, 3'b000, 1'b0, 1'b0);
        resetBoth("halt");
        step();
        step();
        step();
        checkOutput("halt.enter", {obs.st, obs.halted}, 'b1011_1);
        badHalt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (obs.st != 4'd11 || !obs.halted ||
                {obs.rw, obs.wpc, obs.wi, obs.lab, obs.lalu, obs.regw, obs.memwr, obs.m2r} != 8'd0)
                badHalt++;
        end
        checkOutput("halt.sticky20", badHalt, 0);
        #2;
        RST = 1'b1;
        #1;
        checkOutput("halt.rstExit", {obs.st, obs.halted, obs.rw}, 'b0000_0_1);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Reset pulse in the second MEM_RD cycle at MEM_LAT=3 aborts the load
        useL3 = 1'b1;
        applyStimulus(7'b0000011, 3'b010, 1'b0, 1'b0);
        resetBoth("abort");
        for (int i = 0; i < 7; i++) step();
        checkOutput("abort.inMemRd2", obs.st, 6);
        #2;
        RST = 1'b1;
        #1;
        checkOutput("abort.async", {obs.st, obs.rw, obs.regw}, 'b0000_1_0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        expSeq = '{0, 1, 1, 1, 2};
        runSeq("abort");
        checkOutput("abort.regwCnt", regwCnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule

// File: doc/unidade_controle.md
UNIDADE_CONTROLE -- requirements
Module: unidade_controle

Interface
REQ-001 Parameter MEM_LAT, default 1, SHALL set memory read latency in cycles; legal range 1..7.
REQ-002 Port CLK  in  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 Port RST  in  1  SHALL be the reset: asynchronous, active-high.
REQ-004 Port opcode  in  7  SHALL carry instruction bits 6:0 from the instruction register.
REQ-005 Port funct3  in  3  SHALL carry instruction bits 14:12.
REQ-006 Port funct7_5  in  1  SHALL carry instruction bit 30.
REQ-007 Port zero  in  1  SHALL carry the ALU equal-to-zero flag.
REQ-008 Port reset_wire  out  1  SHALL drive synchronous clear of PC and register file.
REQ-009 Ports WRITE_PC, WRITE_INSTRUCTION, load_ab, load_aluout, reg_write, mem_data_wr, mem_to_reg  out  1 each  SHALL be one-hot-in-time strobes.
REQ-010 Ports alu_src_a  out  1 (0=PC, 1=A); alu_src_b  out  2 (00=B, 01=const 4, 10=imm); pc_src  out  1 (0=ALU result, 1=ALUOut).
REQ-011 Port operacao  out  3  SHALL select the ALU op: 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR, 000 pass A.
REQ-012 Ports state_out  out  4 (current state code) and halted  out  1.

Function
REQ-013 States SHALL be RESET(0), FETCH(1), DECODE(2), EXEC_R(3), EXEC_I(4), ADDR(5), MEM_RD(6), MEM_WB(7), MEM_WR(8), ALU_WB(9), BRANCH(10), HALT(11).
REQ-014 Any output not stated active in a state SHALL be 0 in that state.
REQ-015 RESET SHALL assert reset_wire for exactly one cycle, then go to FETCH.
REQ-016 FETCH SHALL last MEM_LAT cycles via a 3-bit down-counter loaded on entry; on its last cycle assert WRITE_INSTRUCTION, WRITE_PC, alu_src_a=0, alu_src_b=01, operacao=ADD, pc_src=0.
REQ-017 DECODE SHALL assert load_ab and load_aluout with alu_src_a=0, alu_src_b=10, operacao=ADD (branch target), then dispatch on opcode.
REQ-018 Dispatch: 0110011->EXEC_R; 0010011->EXEC_I; 0000011->ADDR(load); 0100011->ADDR(store); 1100011->BRANCH; any other opcode->HALT.
REQ-019 EXEC_R: alu_src_a=1, alu_src_b=00, load_aluout; operacao from {funct7_5,funct3}: 0/000 ADD, 1/000 SUB, x/111 AND, x/110 OR, x/100 XOR; other combinations->HALT instead of ALU_WB.
REQ-020 EXEC_I: as EXEC_R with alu_src_b=10, funct7_5 ignored (000 ADD, 111 AND, 110 OR, 100 XOR); other funct3->HALT.
REQ-021 ALU_WB: reg_write=1, mem_to_reg=0, then FETCH.
REQ-022 ADDR: alu_src_a=1, alu_src_b=10, ADD, load_aluout; next MEM_RD if load, MEM_WR if store (opcode latched at DECODE).
REQ-023 MEM_RD SHALL last MEM_LAT cycles (same counter), then MEM_WB; MEM_WB: reg_write=1, mem_to_reg=1, then FETCH.
REQ-024 MEM_WR: mem_data_wr=1 for exactly one cycle, then FETCH.
REQ-025 BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_src=1; WRITE_PC = zero for funct3=000 (BEQ), ~zero for 001 (BNE); other funct3->HALT; otherwise next FETCH.
REQ-026 HALT SHALL be sticky until RST, with halted=1 and all strobes 0.
REQ-027 Instruction cycle counts SHALL be: R/I 3+MEM_LAT, load 3+2*MEM_LAT, store 3+MEM_LAT, branch 2+MEM_LAT.

Reset
REQ-028 RST=1 SHALL force state RESET, counter 0, halted 0, all strobes 0 except reset_wire=1, immediately and independent of CLK.
REQ-029 RST asserted mid-instruction (any state, including mid-counter) SHALL abort it with no further strobe; first FETCH completes MEM_LAT+1 cycles after RST release.

Verification
REQ-030 MEM_LAT=1, opcode 0110011, funct7_5=1, funct3=000 -> states 0,1,2,3,9,1; operacao=010 in EXEC_R; reg_write high one cycle.
REQ-031 MEM_LAT=3, load 0000011 -> FETCH 3 cycles, MEM_RD 3 cycles, MEM_WB mem_to_reg=1; total 9 cycles.
REQ-032 BEQ with zero=1 -> WRITE_PC=1, pc_src=1 in BRANCH; with zero=0 -> WRITE_PC=0; BNE inverse.
REQ-033 Opcode 1111111 at DECODE -> HALT, halted=1 held 20 cycles, no strobes; RST -> RESET.
REQ-034 RST pulse during second MEM_RD cycle (MEM_LAT=3) -> reg_write never asserts; reset_wire=1 next; FETCH resumes.
REQ-035 Store 0100011 -> mem_data_wr high exactly one cycle in MEM_WR, reg_write never high.
